fde_frame_sequencer: RTL and testbench
======================================

Name: fde_frame_sequencer

Overview:
- Frame-level controller for the frequency-domain equalizer datapath.
- Pulls one FFT frame of NFFT bins from the upstream frame buffer and drives the history buffer with one contiguous valid burst, so the buffer's bin index stays aligned.
- Issues coefficient-RAM read addresses aligned to that burst, then sequences the write-back of updated W0/W1 coefficients.
- Guarantees the single-port coefficient RAM is never read and written in the same cycle.

Parameters:
- NFFT, 32, bins per frame; power of two.
- AW, 5, bin address width; log2(NFFT).
- UPD_TIMEOUT, 256, maximum cycles allowed in UPD for NFFT write-back beats.
- TW, 9, timeout counter width; must hold UPD_TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i_frm_avail  in  1  level; upstream buffer holds a complete frame.
- o_frm_pop  out  1  one-cycle pulse; frame consumed, upstream may release it.
- o_fft_rd_en  out  1  FFT frame buffer read enable.
- o_fft_rd_addr  out  AW  FFT frame buffer bin address.
- o_w_rd_en  out  1  coefficient RAM read enable.
- o_w_rd_addr  out  AW  coefficient RAM read address.
- o_hb_valid  out  1  history buffer i_valid; high exactly NFFT consecutive cycles per frame.
- i_adapt_en  in  1  adaptation enable; sampled in IDLE at frame start.
- i_upd_valid  in  1  one updated coefficient pair is ready on the write-data bus.
- o_w_wr_en  out  1  coefficient RAM write enable.
- o_w_wr_addr  out  AW  coefficient RAM write address.
- o_frame_done  out  1  one-cycle pulse at frame completion.
- o_frame_cnt  out  16  completed-frame counter; wraps.
- o_busy  out  1  high whenever state is not IDLE.
- o_err  out  2  sticky error flags: bit0 = update timeout, bit1 = stray i_upd_valid.
- i_err_clr  in  1  clears o_err.

Behaviour:
- Reset: state IDLE. Every output is 0: enables, addresses, pulses, o_frame_cnt, o_err.
- States: IDLE, FEED, DRAIN, UPD, DONE.
- IDLE -> FEED when i_frm_avail = 1. Latch i_adapt_en into adapt_q on this transition.
- FEED:
  - o_fft_rd_en = o_w_rd_en = 1, and o_fft_rd_addr = o_w_rd_addr = bin counter b.
  - b runs 0..NFFT-1, one per cycle, with no gaps.
  - Both RAMs have 1-cycle read latency, so o_hb_valid is o_fft_rd_en delayed by exactly 1 cycle.
  - At b = NFFT-1, go to DRAIN.
- DRAIN:
  - Lasts 1 cycle; carries the last o_hb_valid beat.
  - o_frm_pop pulses here.
  - Next state is UPD if adapt_q = 1, otherwise DONE.
- UPD:
  - Write counter u starts at 0; timeout counter t starts at 0.
  - Each cycle with i_upd_valid = 1: o_w_wr_en = 1 combinationally, o_w_wr_addr = u, then u increments.
  - When the beat with u = NFFT-1 is accepted, go to DONE.
  - t increments every cycle. If t reaches UPD_TIMEOUT before the last beat: set o_err[0] and go to DONE. Remaining bins keep their old coefficients.
- DONE:
  - Lasts 1 cycle. o_frame_done pulses and o_frame_cnt increments.
  - Return to IDLE; a new frame is never started directly from DONE.
  - Back-to-back frames therefore have at least 1 idle cycle between bursts.
- o_hb_valid must never drop inside a burst; the history buffer resets its bin index whenever valid is low.
- RAM mutual exclusion: o_w_rd_en and o_w_wr_en are never high in the same cycle, enforced by the state split.
- Stray beat: i_upd_valid = 1 in any state other than UPD sets o_err[1]. The beat is ignored and no write is issued.
- i_err_clr: clears o_err on the next edge. If an error event occurs in the same cycle, the set wins.
- Mid-operation changes:
  - i_adapt_en changing mid-frame has no effect; adapt_q is used.
  - i_frm_avail dropping during FEED has no effect; the frame is committed.
- Reset mid-frame: returns to IDLE next edge with all outputs 0. The partial burst is abandoned, and no o_frm_pop or o_frame_done is issued.
- o_frame_cnt wraps from 0xFFFF to 0 with no flag.

Decomposition:
- Shared package fde_pkg holds:
  - the state encoding (3-bit enum: IDLE, FEED, DRAIN, UPD, DONE);
  - the NFFT and AW defaults;
  - the error-bit index constants ERR_TIMEOUT = 0 and ERR_STRAY = 1.
- One natural sub-module: fde_bin_counter, a reusable AW-bit counter with start, increment enable, and terminal-count flag. It is instantiated twice, for b and u.

Test Plan:
- Single frame, adapt on: hold i_frm_avail, feed NFFT i_upd_valid beats ->
  - o_hb_valid high 32 consecutive cycles, starting 1 cycle after the first o_fft_rd_en;
  - read addresses 0..31; write addresses 0..31;
  - o_frm_pop at DRAIN; o_frame_done once; o_frame_cnt = 1.
- Adapt off (i_adapt_en = 0 at start) -> no o_w_wr_en, DONE reached 2 cycles after the last read; o_frame_cnt increments.
- Gappy updates (i_upd_valid every 3rd cycle) -> 32 writes with contiguous addresses; no read/write enable overlap at any cycle.
- Timeout: only 10 update beats, UPD_TIMEOUT = 256 -> o_err = 2'b01 after 256 UPD cycles, frame completes. i_err_clr then returns o_err to 0.
- Stray i_upd_valid during FEED -> o_err[1] = 1, o_w_wr_en stays 0, burst unaffected.
- rst asserted at bin 15 of FEED -> all outputs 0 next cycle, no o_frm_pop. With i_frm_avail held, the next frame restarts at address 0.

Source files
------------

// File: rtl/fde_frame_sequencer_pkg.sv
// Shared definitions for the frequency-domain equalizer frame sequencer:
// FSM state encoding, default geometry and error-flag bit positions.
package fde_pkg;

  // Default frame geometry: bins per frame and the matching address width.
  localparam int NFFT_DEF        = 32;
  localparam int AW_DEF          = 5;

  // Default write-back watchdog: cycles allowed in UPD and its counter width.
  localparam int UPD_TIMEOUT_DEF = 256;
  localparam int TW_DEF          = 9;

  // Sticky error flag layout.
  localparam int ERR_TIMEOUT     = 0;
  localparam int ERR_STRAY       = 1;
  localparam int ERR_W           = 2;

  // Frame sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    DRAIN = 3'd2,
    UPD   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fde_frame_sequencer_if.sv
// Bundle of the sequencer's frame-buffer, RAM, history-buffer and status
// signals. The master modport is the sequencer itself; the slave modport is
// the surrounding datapath (or a testbench standing in for it).
interface fde_frame_sequencer_if
  import fde_pkg::*;
#(
  parameter int AW = AW_DEF
);

  // Upstream frame buffer handshake
  logic          i_frm_avail;
  logic          o_frm_pop;
  logic          o_fft_rd_en;
  logic [AW-1:0] o_fft_rd_addr;

  // Coefficient RAM read side
  logic          o_w_rd_en;
  logic [AW-1:0] o_w_rd_addr;

  // History buffer burst qualifier
  logic          o_hb_valid;

  // Coefficient write-back
  logic          i_adapt_en;
  logic          i_upd_valid;
  logic          o_w_wr_en;
  logic [AW-1:0] o_w_wr_addr;

  // Frame status and error reporting
  logic          o_frame_done;
  logic [15:0]   o_frame_cnt;
  logic          o_busy;
  logic [ERR_W-1:0] o_err;
  logic          i_err_clr;

  modport master (
    input  i_frm_avail, i_adapt_en, i_upd_valid, i_err_clr,
    output o_frm_pop, o_fft_rd_en, o_fft_rd_addr, o_w_rd_en, o_w_rd_addr,
           o_hb_valid, o_w_wr_en, o_w_wr_addr, o_frame_done, o_frame_cnt,
           o_busy, o_err
  );

  modport slave (
    output i_frm_avail, i_adapt_en, i_upd_valid, i_err_clr,
    input  o_frm_pop, o_fft_rd_en, o_fft_rd_addr, o_w_rd_en, o_w_rd_addr,
           o_hb_valid, o_w_wr_en, o_w_wr_addr, o_frame_done, o_frame_cnt,
           o_busy, o_err
  );

endinterface

// File: rtl/fde_frame_sequencer_bin_counter.sv
// Reusable bin counter: clears on start (start has priority), advances on inc
// and flags the terminal bin. Used for both the read bin and write-back bin.
module fde_bin_counter
  import fde_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int LAST = NFFT_DEF - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          inc,
  output logic [AW-1:0] cnt,
  output logic          tc
);

  logic [AW-1:0] cnt_reg;
  logic [AW-1:0] cnt_next;

  // Next count: start forces bin 0, otherwise step on inc.
  always_comb begin
    cnt_next = cnt_reg;
    if (start) begin
      cnt_next = '0;
    end else if (inc) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;
  assign tc  = (cnt_reg == AW'(LAST));

endmodule

// File: rtl/fde_frame_sequencer.sv
// Frame-level controller for the FDE datapath. Streams one FFT frame as a
// single gap-free burst into the history buffer with aligned coefficient
// reads, then sequences coefficient write-back. Reads only happen in FEED and
// writes only in UPD, so the single-port coefficient RAM never sees both.
module fde_frame_sequencer
  import fde_pkg::*;
#(
  parameter int NFFT        = NFFT_DEF,
  parameter int AW          = AW_DEF,
  parameter int UPD_TIMEOUT = UPD_TIMEOUT_DEF,
  parameter int TW          = TW_DEF
) (
  input logic                  clk,
  input logic                  rst,
  fde_frame_sequencer_if.master bus
);

  state_t            state_reg;
  state_t            state_next;

  logic              adapt_q_reg;
  logic              hb_valid_reg;
  logic [15:0]       frame_cnt_reg;
  logic [TW-1:0]     t_reg;
  logic [ERR_W-1:0]  err_reg;
  logic [ERR_W-1:0]  err_next;
  logic [ERR_W-1:0]  err_set;

  logic              in_feed;
  logic              in_drain;
  logic              in_upd;
  logic              in_done;
  logic              wr_fire;
  logic              timeout_hit;

  logic [AW-1:0]     b_cnt;
  logic              b_tc;
  logic [AW-1:0]     u_cnt;
  logic              u_tc;

  // Read bin b: parked at 0 outside FEED so every burst starts at bin 0.
  fde_bin_counter #(
    .AW   (AW),
    .LAST (NFFT - 1)
  ) u_b_counter (
    .clk   (clk),
    .rst   (rst),
    .start (state_reg != FEED),
    .inc   (in_feed),
    .cnt   (b_cnt),
    .tc    (b_tc)
  );

  // Write-back bin u: parked at 0 outside UPD, advances on accepted beats.
  fde_bin_counter #(
    .AW   (AW),
    .LAST (NFFT - 1)
  ) u_u_counter (
    .clk   (clk),
    .rst   (rst),
    .start (state_reg != UPD),
    .inc   (wr_fire),
    .cnt   (u_cnt),
    .tc    (u_tc)
  );

  // Next-state and per-state strobes; the watchdog only fires if the final
  // beat is not accepted in its last allowed cycle.
  always_comb begin
    state_next  = state_reg;
    in_feed     = 1'b0;
    in_drain    = 1'b0;
    in_upd      = 1'b0;
    in_done     = 1'b0;
    wr_fire     = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.i_frm_avail) begin
          state_next = FEED;
        end
      end
      FEED: begin
        in_feed = 1'b1;
        if (b_tc) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        in_drain   = 1'b1;
        state_next = adapt_q_reg ? UPD : DONE;
      end
      UPD: begin
        in_upd  = 1'b1;
        wr_fire = bus.i_upd_valid;
        if (bus.i_upd_valid && u_tc) begin
          state_next = DONE;
        end else if (t_reg == TW'(UPD_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        in_done    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the adaptation mode once, at frame start; later changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      adapt_q_reg <= 1'b0;
    end else if (state_reg == IDLE && bus.i_frm_avail) begin
      adapt_q_reg <= bus.i_adapt_en;
    end
  end

  // History-buffer valid follows the read enable by the RAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_valid_reg <= 1'b0;
    end else begin
      hb_valid_reg <= in_feed;
    end
  end

  // Write-back watchdog: counts every cycle spent in UPD, cleared elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_reg <= '0;
    end else if (in_upd) begin
      t_reg <= t_reg + 1'b1;
    end else begin
      t_reg <= '0;
    end
  end

  // Completed-frame counter, free-running wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (in_done) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  // Error events; a stray update beat is any beat presented outside UPD.
  assign err_set[ERR_TIMEOUT] = timeout_hit;
  assign err_set[ERR_STRAY]   = bus.i_upd_valid && (state_reg != UPD);

  // Per-flag sticky update: a same-cycle event beats the clear request.
  for (genvar gi = 0; gi < ERR_W; gi++) begin : g_err
    assign err_next[gi] = err_set[gi] | (err_reg[gi] & ~bus.i_err_clr);
  end

  // Sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= '0;
    end else begin
      err_reg <= err_next;
    end
  end

  // Outputs; addresses are held at 0 whenever their enable is idle.
  assign bus.o_fft_rd_en   = in_feed;
  assign bus.o_fft_rd_addr = in_feed ? b_cnt : '0;
  assign bus.o_w_rd_en     = in_feed;
  assign bus.o_w_rd_addr   = in_feed ? b_cnt : '0;
  assign bus.o_hb_valid    = hb_valid_reg;
  assign bus.o_frm_pop     = in_drain;
  assign bus.o_w_wr_en     = wr_fire;
  assign bus.o_w_wr_addr   = in_upd ? u_cnt : '0;
  assign bus.o_frame_done  = in_done;
  assign bus.o_frame_cnt   = frame_cnt_reg;
  assign bus.o_busy        = (state_reg != IDLE);
  assign bus.o_err         = err_reg;

endmodule

// File: tb/tb_fde_frame_sequencer.sv
// Self-checking bench for fde_frame_sequencer. Read and write addresses are
// predicted into scoreboard queues as stimulus is driven and retired by a
// monitor as the DUT issues them; scenario tasks check timing and status.
module tb_fde_frame_sequencer;
  import fde_pkg::*;

  localparam int NFFT        = 32;
  localparam int AW          = 5;
  localparam int UPD_TIMEOUT = 256;
  localparam int TW          = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fde_frame_sequencer_if #(.AW(AW)) bus ();

  fde_frame_sequencer #(
    .NFFT        (NFFT),
    .AW          (AW),
    .UPD_TIMEOUT (UPD_TIMEOUT),
    .TW          (TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_rd_q[$];
  int exp_wr_q[$];
  int pop_cnt = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int exp_cnt = 0;

  // Monitor state
  logic          prev_rd = 1'b0;
  logic          prev_rst = 1'b1;
  int            hb_run = 0;
  int            mon_e;
  logic [AW-1:0] mon_a;
  logic          mon_hb;

  // Per-cycle monitor, sampled after the scenario tasks have set inputs.
  always @(negedge clk) begin
    #2;
    if (bus.o_fft_rd_en) begin
      n_cmp++;
      if (exp_rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: got read addr %0d, required no read", bus.o_fft_rd_addr);
      end else begin
        mon_e = exp_rd_q.pop_front();
        mon_a = AW'(mon_e);
        if (bus.o_fft_rd_addr !== mon_a || bus.o_w_rd_addr !== mon_a) begin
          n_bad++;
          $display("FAIL rd_addr: got fft=%0d w=%0d, required %0d",
                   bus.o_fft_rd_addr, bus.o_w_rd_addr, mon_a);
        end
      end
    end
    if (bus.o_w_wr_en) begin
      n_cmp++;
      wr_cnt++;
      if (exp_wr_q.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected: got write addr %0d, required no write", bus.o_w_wr_addr);
      end else begin
        mon_e = exp_wr_q.pop_front();
        mon_a = AW'(mon_e);
        if (bus.o_w_wr_addr !== mon_a) begin
          n_bad++;
          $display("FAIL wr_addr: got %0d, required %0d", bus.o_w_wr_addr, mon_a);
        end
      end
    end
    if (bus.o_w_rd_en || bus.o_w_wr_en) begin
      n_cmp++;
      if (bus.o_w_rd_en && bus.o_w_wr_en) begin
        n_bad++;
        $display("FAIL ram_overlap: got rd_en=1 wr_en=1, required at most one");
      end
    end
    mon_hb = prev_rd && !prev_rst;
    if (bus.o_hb_valid || mon_hb) begin
      n_cmp++;
      if (bus.o_hb_valid !== mon_hb) begin
        n_bad++;
        $display("FAIL hb_valid: got %b, required %b", bus.o_hb_valid, mon_hb);
      end
    end
    if (bus.o_hb_valid === 1'b1) begin
      hb_run++;
    end else if (hb_run > 0) begin
      if (!prev_rst) begin
        n_cmp++;
        if (hb_run != NFFT) begin
          n_bad++;
          $display("FAIL hb_burst_len: got %0d, required %0d", hb_run, NFFT);
        end
      end
      hb_run = 0;
    end
    if (bus.o_frm_pop === 1'b1) pop_cnt++;
    if (bus.o_frame_done === 1'b1) done_cnt++;
    prev_rd  = bus.o_fft_rd_en;
    prev_rst = rst;
  end

  // Stimulus helper: runs one frame, predicting reads/writes into the queues,
  // and reports the pop/done cycles relative to the IDLE cycle that sees
  // i_frm_avail. Checks are made by the calling scenario.
  task automatic do_frame(input bit adapt, input int beats, input int period,
                          input int stray_cyc, output int pop_cyc,
                          output int done_cyc, output logic [1:0] err_done,
                          output bit hung);
    int  cyc;
    int  upd_idx;
    int  sent;
    bit  upd_on;
    pop_cyc  = -1;
    done_cyc = -1;
    err_done = 2'b00;
    hung     = 1'b1;
    upd_on   = 1'b0;
    upd_idx  = 0;
    sent     = 0;
    @(negedge clk);
    bus.i_adapt_en  = adapt;
    bus.i_frm_avail = 1'b1;
    bus.i_upd_valid = 1'b0;
    for (int k = 0; k < NFFT; k++) exp_rd_q.push_back(k);
    cyc = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      cyc++;
      bus.i_adapt_en  = ~adapt;
      bus.i_upd_valid = 1'b0;
      if (cyc == stray_cyc) bus.i_upd_valid = 1'b1;
      if (upd_on) begin
        if (sent < beats && (upd_idx % period) == 0) begin
          bus.i_upd_valid = 1'b1;
          exp_wr_q.push_back(sent);
          sent++;
        end
        upd_idx++;
      end
      #1;
      if (bus.o_frm_pop === 1'b1) begin
        pop_cyc         = cyc;
        bus.i_frm_avail = 1'b0;
        upd_on          = adapt;
      end
      if (bus.o_frame_done === 1'b1) begin
        done_cyc = cyc;
        err_done = bus.o_err;
        hung     = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [39:0] outs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    outs = {bus.o_fft_rd_en, bus.o_fft_rd_addr, bus.o_w_rd_en, bus.o_w_rd_addr,
            bus.o_hb_valid, bus.o_frm_pop, bus.o_w_wr_en, bus.o_w_wr_addr,
            bus.o_frame_done, bus.o_frame_cnt, bus.o_busy, bus.o_err};
    n_cmp++;
    if (outs !== 40'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_frame_cnt !== 16'd0 || bus.o_err !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%b cnt=%0d err=%b, required 0/0/00",
               bus.o_busy, bus.o_frame_cnt, bus.o_err);
    end
  endtask

  task automatic test_adapt_on();
    int pc, dc, w0, p0, d0;
    logic [1:0] ed;
    bit hung;
    w0 = wr_cnt; p0 = pop_cnt; d0 = done_cnt;
    do_frame(1'b1, NFFT, 1, -1, pc, dc, ed, hung);
    n_cmp++;
    if (hung) begin n_bad++; $display("FAIL adapt_on_timeout: got no frame_done, required one"); end
    n_cmp++;
    if (pc != NFFT + 1) begin n_bad++; $display("FAIL adapt_on_pop_cycle: got %0d, required %0d", pc, NFFT + 1); end
    n_cmp++;
    if (dc - pc != NFFT + 1) begin n_bad++; $display("FAIL adapt_on_done_cycle: got %0d, required %0d", dc - pc, NFFT + 1); end
    n_cmp++;
    if (ed !== 2'b00) begin n_bad++; $display("FAIL adapt_on_err: got %b, required 00", ed); end
    @(negedge clk);
    #1;
    exp_cnt++;
    n_cmp++;
    if (bus.o_frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL adapt_on_frame_cnt: got %0d, required %0d", bus.o_frame_cnt, exp_cnt); end
    n_cmp++;
    if (wr_cnt - w0 != NFFT) begin n_bad++; $display("FAIL adapt_on_writes: got %0d, required %0d", wr_cnt - w0, NFFT); end
    n_cmp++;
    if (pop_cnt - p0 != 1 || done_cnt - d0 != 1) begin
      n_bad++; $display("FAIL adapt_on_pulses: got pop=%0d done=%0d, required 1/1", pop_cnt - p0, done_cnt - d0);
    end
    n_cmp++;
    if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL adapt_on_busy: got %b, required 0", bus.o_busy); end
  endtask

  task automatic test_adapt_off();
    int pc, dc, w0;
    logic [1:0] ed;
    bit hung;
    w0 = wr_cnt;
    do_frame(1'b0, 0, 1, -1, pc, dc, ed, hung);
    n_cmp++;
    if (hung) begin n_bad++; $display("FAIL adapt_off_timeout: got no frame_done, required one"); end
    n_cmp++;
    if (dc != NFFT + 2) begin n_bad++; $display("FAIL adapt_off_done_cycle: got %0d, required %0d", dc, NFFT + 2); end
    @(negedge clk);
    #1;
    exp_cnt++;
    n_cmp++;
    if (bus.o_frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL adapt_off_frame_cnt: got %0d, required %0d", bus.o_frame_cnt, exp_cnt); end
    n_cmp++;
    if (wr_cnt != w0) begin n_bad++; $display("FAIL adapt_off_writes: got %0d, required 0", wr_cnt - w0); end
  endtask

  task automatic test_gappy();
    int pc, dc, w0;
    logic [1:0] ed;
    bit hung;
    w0 = wr_cnt;
    do_frame(1'b1, NFFT, 3, -1, pc, dc, ed, hung);
    n_cmp++;
    if (hung) begin n_bad++; $display("FAIL gappy_timeout: got no frame_done, required one"); end
    n_cmp++;
    if (dc - pc != 3 * (NFFT - 1) + 2) begin n_bad++; $display("FAIL gappy_done_cycle: got %0d, required %0d", dc - pc, 3 * (NFFT - 1) + 2); end
    n_cmp++;
    if (wr_cnt - w0 != NFFT) begin n_bad++; $display("FAIL gappy_writes: got %0d, required %0d", wr_cnt - w0, NFFT); end
    @(negedge clk);
    #1;
    exp_cnt++;
    n_cmp++;
    if (bus.o_frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL gappy_frame_cnt: got %0d, required %0d", bus.o_frame_cnt, exp_cnt); end
  endtask

  task automatic test_timeout();
    int pc, dc, w0;
    logic [1:0] ed;
    bit hung;
    w0 = wr_cnt;
    do_frame(1'b1, 10, 1, -1, pc, dc, ed, hung);
    n_cmp++;
    if (hung) begin n_bad++; $display("FAIL timeout_hang: got no frame_done, required one"); end
    n_cmp++;
    if (dc - pc != UPD_TIMEOUT + 1) begin n_bad++; $display("FAIL timeout_done_cycle: got %0d, required %0d", dc - pc, UPD_TIMEOUT + 1); end
    n_cmp++;
    if (ed !== 2'b01) begin n_bad++; $display("FAIL timeout_err: got %b, required 01", ed); end
    n_cmp++;
    if (wr_cnt - w0 != 10) begin n_bad++; $display("FAIL timeout_writes: got %0d, required 10", wr_cnt - w0); end
    @(negedge clk);
    #1;
    exp_cnt++;
    n_cmp++;
    if (bus.o_frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL timeout_frame_cnt: got %0d, required %0d", bus.o_frame_cnt, exp_cnt); end
    // Clear the flag.
    @(negedge clk);
    bus.i_err_clr = 1'b1;
    @(negedge clk);
    bus.i_err_clr = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_err !== 2'b00) begin n_bad++; $display("FAIL err_clear: got %b, required 00", bus.o_err); end
    // Clear and a stray beat in the same cycle: the set wins.
    @(negedge clk);
    bus.i_err_clr   = 1'b1;
    bus.i_upd_valid = 1'b1;
    @(negedge clk);
    bus.i_err_clr   = 1'b0;
    bus.i_upd_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_err !== 2'b10) begin n_bad++; $display("FAIL err_set_wins: got %b, required 10", bus.o_err); end
    @(negedge clk);
    bus.i_err_clr = 1'b1;
    @(negedge clk);
    bus.i_err_clr = 1'b0;
  endtask

  task automatic test_stray();
    int pc, dc, w0;
    logic [1:0] ed;
    bit hung;
    w0 = wr_cnt;
    do_frame(1'b1, NFFT, 1, 5, pc, dc, ed, hung);
    n_cmp++;
    if (hung) begin n_bad++; $display("FAIL stray_hang: got no frame_done, required one"); end
    n_cmp++;
    if (ed !== 2'b10) begin n_bad++; $display("FAIL stray_err: got %b, required 10", ed); end
    n_cmp++;
    if (pc != NFFT + 1 || dc - pc != NFFT + 1) begin
      n_bad++; $display("FAIL stray_timing: got pop=%0d done-pop=%0d, required %0d/%0d", pc, dc - pc, NFFT + 1, NFFT + 1);
    end
    n_cmp++;
    if (wr_cnt - w0 != NFFT) begin n_bad++; $display("FAIL stray_writes: got %0d, required %0d", wr_cnt - w0, NFFT); end
    @(negedge clk);
    #1;
    exp_cnt++;
    bus.i_err_clr = 1'b1;
    n_cmp++;
    if (bus.o_frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL stray_frame_cnt: got %0d, required %0d", bus.o_frame_cnt, exp_cnt); end
    @(negedge clk);
    bus.i_err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [39:0] outs;
    bit found;
    bit hung;
    int p0, d0;
    found = 1'b0;
    hung  = 1'b1;
    @(negedge clk);
    bus.i_adapt_en  = 1'b0;
    bus.i_frm_avail = 1'b1;
    for (int k = 0; k < NFFT; k++) exp_rd_q.push_back(k);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (bus.o_fft_rd_en === 1'b1 && bus.o_fft_rd_addr === 5'd15) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL rst_mid_reach_bin15: got no bin 15 read, required one"); end
    n_cmp++;
    if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy: got %b, required 1", bus.o_busy); end
    rst = 1'b1;
    p0 = pop_cnt;
    d0 = done_cnt;
    @(negedge clk);
    #1;
    exp_rd_q.delete();
    exp_cnt = 0;
    outs = {bus.o_fft_rd_en, bus.o_fft_rd_addr, bus.o_w_rd_en, bus.o_w_rd_addr,
            bus.o_hb_valid, bus.o_frm_pop, bus.o_w_wr_en, bus.o_w_wr_addr,
            bus.o_frame_done, bus.o_frame_cnt, bus.o_busy, bus.o_err};
    n_cmp++;
    if (outs !== 40'd0) begin n_bad++; $display("FAIL rst_mid_outputs: got %h, required 0", outs); end
    // Release with i_frm_avail still held: a fresh frame starts at bin 0.
    rst = 1'b0;
    for (int k = 0; k < NFFT; k++) exp_rd_q.push_back(k);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (bus.o_frm_pop === 1'b1) bus.i_frm_avail = 1'b0;
      if (bus.o_frame_done === 1'b1) begin
        hung = 1'b0;
        break;
      end
    end
    n_cmp++;
    if (hung) begin n_bad++; $display("FAIL rst_mid_restart: got no frame_done, required one"); end
    @(negedge clk);
    #1;
    exp_cnt++;
    n_cmp++;
    if (pop_cnt - p0 != 1 || done_cnt - d0 != 1) begin
      n_bad++; $display("FAIL rst_mid_pulses: got pop=%0d done=%0d, required 1/1", pop_cnt - p0, done_cnt - d0);
    end
    n_cmp++;
    if (bus.o_frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL rst_mid_frame_cnt: got %0d, required %0d", bus.o_frame_cnt, exp_cnt); end
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_frm_avail = 1'b0;
    bus.i_adapt_en  = 1'b0;
    bus.i_upd_valid = 1'b0;
    bus.i_err_clr   = 1'b0;
    test_reset();
    test_adapt_on();
    test_adapt_off();
    test_gappy();
    test_timeout();
    test_stray();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    #3;
    n_cmp++;
    if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got rd=%0d wr=%0d left, required 0/0", exp_rd_q.size(), exp_wr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
